mmv_ram_responder: RTL and testbench

- Synthesizable MemoryMapped (mmv) slave: on-chip RAM behind the s_addr/s_wreq/s_wdat/s_rreq/s_rdat/s_rval/s_busy interface.
- Fixed, parameterizable read latency and a cap on outstanding reads.
- Self-initialising sweep after reset or clear.
- Responder end for mmv masters such as mmv_ram_db_tester; replaces the behavioural slave model in hardware.

---
 rtl/mmv_ram_responder_pkg.sv | 15 +
 rtl/mmv_ram_responder_rdpipe.sv | 50 +++++
 rtl/mmv_ram_responder.sv | 156 +++++++++++++++
 tb/tb_mmv_ram_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmv_ram_responder_pkg.sv
// Shared types and helpers for the mmv RAM responder.
package mmv_ram_responder_pkg;

   // Top-level controller state: sweeping memory or serving requests.
   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   // Width of a counter that must hold 0..max_pend inclusive.
   function automatic int unsigned pend_width(input int unsigned max_pend);
      return (max_pend < 1) ? 1 : $clog2(max_pend + 1);
   endfunction

endpackage

// File: rtl/mmv_ram_responder_rdpipe.sv
// {valid, data} delay line with synchronous flush.
// Ports: clk, reset (sync, active-high), flush (drops all valids),
//        in_vld/in_dat (stage input), out_vld/out_dat (DEPTH clocks later).
// DEPTH = 0 degenerates to a wire.
module mmv_ram_responder_rdpipe #(
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned DWIDTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_vld,
   input  logic [DWIDTH-1:0] in_dat,
   output logic              out_vld,
   output logic [DWIDTH-1:0] out_dat
);

   if (DEPTH == 0) begin : g_thru
      logic unused_ok;
      assign unused_ok = ^{clk, reset, flush};
      assign out_vld   = in_vld;
      assign out_dat   = in_dat;
   end else begin : g_pipe
      logic [DEPTH-1:0]  vld_q;
      logic [DWIDTH-1:0] dat_q [DEPTH];

      // Valid bits carry the reset/flush; data just follows along.
      always_ff @(posedge clk) begin
         if (reset || flush) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= in_vld;
            for (int i = 1; i < int'(DEPTH); i++) begin
               vld_q[i] <= vld_q[i-1];
            end
         end
      end

      always_ff @(posedge clk) begin
         dat_q[0] <= in_dat;
         for (int i = 1; i < int'(DEPTH); i++) begin
            dat_q[i] <= dat_q[i-1];
         end
      end

      assign out_vld = vld_q[DEPTH-1];
      assign out_dat = dat_q[DEPTH-1];
   end

endmodule

// File: rtl/mmv_ram_responder.sv
// mmv slave backed by on-chip RAM with fixed read latency, a cap on
// outstanding reads and a self-initialising sweep after reset/clear.
// Ports: clk, reset (sync, active-high), clear (sync re-init),
//        s_addr/s_wreq/s_wdat/s_rreq (requests), s_rdat/s_rval (read return),
//        s_busy (request not accepted this cycle), init_done (sweep-done pulse).
module mmv_ram_responder
   import mmv_ram_responder_pkg::*;
#(
   parameter int unsigned       AWIDTH  = 8,
   parameter int unsigned       DWIDTH  = 8,
   parameter int unsigned       RDDELAY = 4,
   parameter int unsigned       MAXPEND = 4,
   parameter logic [DWIDTH-1:0] INITVAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [AWIDTH-1:0] s_addr,
   input  logic              s_wreq,
   input  logic [DWIDTH-1:0] s_wdat,
   input  logic              s_rreq,
   output logic [DWIDTH-1:0] s_rdat,
   output logic              s_rval,
   output logic              s_busy,
   output logic              init_done
);

   localparam int unsigned    MEM_DEPTH  = 1 << AWIDTH;
   localparam int unsigned    PW         = pend_width(MAXPEND);
   localparam logic [AWIDTH:0] SWEEP_LAST = {1'b0, {AWIDTH{1'b1}}};
   localparam logic [AWIDTH:0] SWEEP_ONE  = {{AWIDTH{1'b0}}, 1'b1};

   if (RDDELAY < 1) begin : g_chk_rddelay
      $error("mmv_ram_responder: RDDELAY must be >= 1");
   end
   if ((MAXPEND < 1) || (MAXPEND > RDDELAY)) begin : g_chk_maxpend
      $error("mmv_ram_responder: MAXPEND must be in 1..RDDELAY");
   end

   state_t            state_q, state_d;
   logic [AWIDTH:0]   sweep_q, sweep_d;
   logic [PW-1:0]     pend_q, pend_d;
   logic              init_done_d;
   logic              flush;
   logic              acc_rd, acc_wr;
   logic              mem_we;
   logic [AWIDTH-1:0] mem_addr;
   logic [DWIDTH-1:0] mem_wdat;
   logic [DWIDTH-1:0] mem [MEM_DEPTH];
   logic              rd_vld_q;
   logic [DWIDTH-1:0] rd_dat_q;
   logic              pipe_vld;
   logic [DWIDTH-1:0] pipe_dat;

   // Busy comes straight from registered state; inputs never feed it.
   assign s_busy = (state_q == ST_INIT) || (pend_q == PW'(MAXPEND));

   // Next-state, sweep, acceptance, RAM port mux and pending-count update.
   always_comb begin
      state_d     = state_q;
      sweep_d     = sweep_q;
      init_done_d = 1'b0;
      flush       = 1'b0;
      acc_rd      = 1'b0;
      acc_wr      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = s_addr;
      mem_wdat    = s_wdat;
      pend_d      = pend_q;

      unique case (state_q)
         ST_INIT: begin
            mem_we   = 1'b1;
            mem_addr = sweep_q[AWIDTH-1:0];
            mem_wdat = INITVAL;
            if (clear) begin
               sweep_d = '0;
            end else if (sweep_q == SWEEP_LAST) begin
               sweep_d     = '0;
               state_d     = ST_READY;
               init_done_d = 1'b1;
            end else begin
               sweep_d = sweep_q + SWEEP_ONE;
            end
         end
         ST_READY: begin
            if (clear) begin
               state_d = ST_INIT;
               sweep_d = '0;
               flush   = 1'b1;
            end else begin
               acc_wr = s_wreq && !s_busy;
               acc_rd = s_rreq && !s_busy;
               mem_we = acc_wr;
            end
         end
         default: state_d = ST_INIT;
      endcase

      // A read retires on the edge that launches its s_rval.
      if (acc_rd && !pipe_vld) begin
         pend_d = pend_q + PW'(1);
      end else if (!acc_rd && pipe_vld) begin
         pend_d = pend_q - PW'(1);
      end
   end

   // Control state, RAM read register and registered read return.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_INIT;
         sweep_q   <= '0;
         pend_q    <= '0;
         init_done <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_dat_q  <= '0;
         s_rval    <= 1'b0;
         s_rdat    <= '0;
      end else begin
         state_q   <= state_d;
         sweep_q   <= sweep_d;
         pend_q    <= flush ? '0 : pend_d;
         init_done <= init_done_d;
         rd_vld_q  <= acc_rd;
         // Write-first: a same-cycle write returns the new data.
         if (acc_rd) begin
            rd_dat_q <= acc_wr ? s_wdat : mem[s_addr];
         end
         s_rval <= pipe_vld && !flush;
         if (pipe_vld && !flush) begin
            s_rdat <= pipe_dat;
         end
      end
   end

   // Single-port RAM; contents are not reset.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[mem_addr] <= mem_wdat;
      end
   end

   mmv_ram_responder_rdpipe #(
      .DEPTH  (RDDELAY - 1),
      .DWIDTH (DWIDTH)
   ) u_rdpipe (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .in_vld  (rd_vld_q),
      .in_dat  (rd_dat_q),
      .out_vld (pipe_vld),
      .out_dat (pipe_dat)
   );

endmodule

// File: tb/tb_mmv_ram_responder.sv
// Directed bench for mmv_ram_responder: instance A (MAXPEND=16) and
// instance B (MAXPEND=2), both RDDELAY=16, INITVAL=8'hA5, AWIDTH=DWIDTH=8.
module tb_mmv_ram_responder;

   logic       clk = 1'b0;
   logic       reset, clear, sel;
   logic [7:0] s_addr, s_wdat;
   logic       s_wreq, rreq;
   logic       a_rreq, b_rreq;
   logic [7:0] a_rdat, b_rdat;
   logic       a_rval, b_rval, a_busy, b_busy, a_done, b_done;
   logic [7:0] rdat_m;
   logic       rval_m, busy_m, done_m;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Reads go to the selected instance; writes go to both.
   assign a_rreq = rreq & ~sel;
   assign b_rreq = rreq & sel;
   assign rdat_m = sel ? b_rdat : a_rdat;
   assign rval_m = sel ? b_rval : a_rval;
   assign busy_m = sel ? b_busy : a_busy;
   assign done_m = sel ? b_done : a_done;

   mmv_ram_responder #(
      .AWIDTH(8), .DWIDTH(8), .RDDELAY(16), .MAXPEND(16), .INITVAL(8'hA5)
   ) u_dut_a (
      .clk(clk), .reset(reset), .clear(clear), .s_addr(s_addr),
      .s_wreq(s_wreq), .s_wdat(s_wdat), .s_rreq(a_rreq), .s_rdat(a_rdat),
      .s_rval(a_rval), .s_busy(a_busy), .init_done(a_done)
   );

   mmv_ram_responder #(
      .AWIDTH(8), .DWIDTH(8), .RDDELAY(16), .MAXPEND(2), .INITVAL(8'hA5)
   ) u_dut_b (
      .clk(clk), .reset(reset), .clear(clear), .s_addr(s_addr),
      .s_wreq(s_wreq), .s_wdat(s_wdat), .s_rreq(b_rreq), .s_rdat(b_rdat),
      .s_rval(b_rval), .s_busy(b_busy), .init_done(b_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Observe 300 cycles starting at the first post-reset/clear sample.
   task automatic wait_init(input string tag);
      int nb = 0;
      int np = 0;
      int nv = 0;
      for (int i = 0; i < 300; i++) begin
         if (busy_m) nb++;
         if (done_m) np++;
         if (rval_m) nv++;
         tick();
      end
      check_eq({tag, "_busy_cycles"}, nb, 256);
      check_eq({tag, "_init_pulses"}, np, 1);
      check_eq({tag, "_stray_rval"}, nv, 0);
   endtask

   task automatic write_one(input logic [7:0] addr, input logic [7:0] data);
      int w = 0;
      s_addr = addr; s_wdat = data; s_wreq = 1'b1;
      while (busy_m && w < 100) begin tick(); w++; end
      if (w == 100) check_eq("wr_accept_timeout", 1, 0);
      tick();
      s_wreq = 1'b0;
   endtask

   // Single read (optionally with a same-cycle write); checks latency and data.
   task automatic read_one(input string tag, input logic [7:0] addr,
                           input logic do_wr, input logic [7:0] wdat,
                           input logic [7:0] exp);
      int w   = 0;
      int lat = 0;
      s_addr = addr; rreq = 1'b1; s_wreq = do_wr; s_wdat = wdat;
      while (busy_m && w < 100) begin tick(); w++; end
      check_eq({tag, "_accept"}, busy_m, 0);
      tick();
      rreq = 1'b0; s_wreq = 1'b0;
      while (!rval_m && lat < 40) begin tick(); lat++; end
      check_eq({tag, "_latency"}, lat, 16);
      check_eq({tag, "_data"}, rdat_m, exp);
      tick();
      check_eq({tag, "_rval_one_cycle"}, rval_m, 0);
      check_eq({tag, "_rdat_hold"}, rdat_m, exp);
   endtask

   // 20 reads of addr 0..19 (holding while busy); data expected = addr.
   task automatic run_burst(input string tag, input int exp_gap);
      int acc_edge[20];
      int nxt   = 0;
      int got   = 0;
      int cyc   = 0;
      int nbusy = 0;
      while (got < 20 && cyc < 1000) begin
         if (rval_m) begin
            if (got < 20) begin
               check_eq({tag, "_data"}, rdat_m, 32'(got));
               check_eq({tag, "_lat"}, cyc - acc_edge[got], 16);
            end
            got++;
         end
         if (nxt < 20) begin
            s_addr = 8'(nxt);
            rreq   = 1'b1;
            if (busy_m) nbusy++;
            else begin
               acc_edge[nxt] = cyc + 1;
               nxt++;
            end
         end else begin
            rreq = 1'b0;
         end
         tick();
         cyc++;
      end
      rreq = 1'b0;
      check_eq({tag, "_count"}, got, 20);
      if (exp_gap > 0) begin
         check_eq({tag, "_gap"}, acc_edge[2] - acc_edge[0], exp_gap);
         check_eq({tag, "_busy_seen"}, (nbusy > 0), 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1);
   end

   initial begin
      int ok;
      int nv;
      int nbad;
      reset = 1'b1; clear = 1'b0; sel = 1'b0;
      s_addr = '0; s_wdat = '0; s_wreq = 1'b0; rreq = 1'b0;
      repeat (3) tick();
      check_eq("rst_busy", busy_m, 1);
      check_eq("rst_rval", rval_m, 0);
      check_eq("rst_rdat", rdat_m, 8'h00);
      check_eq("rst_init_done", done_m, 0);

      // 1: init sweep then default contents
      reset = 1'b0;
      wait_init("t1");
      read_one("t1_rd37", 8'h37, 1'b0, 8'h00, 8'hA5);

      // 2: write then read back
      write_one(8'h10, 8'h3C);
      read_one("t2_rd10", 8'h10, 1'b0, 8'h00, 8'h3C);

      // 3: back-to-back reads, then the same on the MAXPEND=2 instance
      for (int i = 0; i < 20; i++) write_one(8'(i), 8'(i));
      run_burst("t3a", 0);
      sel = 1'b1;
      run_burst("t3b", 17);
      sel = 1'b0;

      // 4: simultaneous write and read is write-first
      read_one("t4_rw", 8'h55, 1'b1, 8'hC3, 8'hC3);
      read_one("t4_rd", 8'h55, 1'b0, 8'h00, 8'hC3);

      // 5: clear drops in-flight reads and re-sweeps
      for (int i = 0; i < 5; i++) begin
         s_addr = 8'(i); rreq = 1'b1; tick();
      end
      rreq = 1'b0;
      repeat (3) tick();
      clear = 1'b1; tick(); clear = 1'b0;
      wait_init("t5");
      read_one("t5_rd10", 8'h10, 1'b0, 8'h00, 8'hA5);

      // 6: reset with reads outstanding
      for (int i = 0; i < 8; i++) begin
         s_addr = 8'(i); rreq = 1'b1; tick();
      end
      rreq = 1'b0;
      tick();
      reset = 1'b1; tick();
      check_eq("t6_rst_rval", rval_m, 0);
      check_eq("t6_rst_busy", busy_m, 1);
      tick();
      reset = 1'b0;
      wait_init("t6");
      ok = 0;
      for (int i = 0; i < 16; i++) begin
         s_addr = 8'(i); rreq = 1'b1;
         if (!busy_m) ok++;
         tick();
      end
      rreq = 1'b0;
      check_eq("t6_accepted_no_busy", ok, 16);
      check_eq("t6_busy_at_cap", busy_m, 1);
      nv = 0; nbad = 0;
      for (int i = 0; i < 40; i++) begin
         if (rval_m) begin
            nv++;
            if (rdat_m !== 8'hA5) nbad++;
         end
         tick();
      end
      check_eq("t6_rval_count", nv, 16);
      check_eq("t6_bad_data", nbad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
